nibble_serial_add_ctrl: RTL and testbench

//  Upstream sequencer for Adder4bit: adds two NIBBLES*4-bit operands one nibble per clock.

---
 rtl/nibble_serial_add_ctrl.sv | 118 +++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial wide adder sequencer driving an external 4-bit adder, one nibble per clock.
// Optional subtract mode (input port sub) is compiled in when SUB_EN is defined.
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   cin_in,
`ifdef SUB_EN
    input  logic                   sub,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_carry
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             state;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic [W-1:0]       acc;
    logic [W-1:0]       acc_nxt;
    logic               carry_reg;
    logic [IDX_W-1:0]   idx;
    logic               last;

    assign last = (idx == IDX_W'(NIBBLES - 1));

    // Accumulator with the current nibble merged in, so the final edge can publish it whole
    always_comb begin
        acc_nxt              = acc;
        acc_nxt[4*idx +: 4]  = add_sum;
    end

    // Adder inputs decode only registered state; nothing from start/op_* reaches them
    always_comb begin
        add_a   = 4'd0;
        add_b   = 4'd0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_reg[4*idx +: 4];
            add_b   = b_reg[4*idx +: 4];
            add_cin = carry_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg <= op_a;
`ifdef SUB_EN
                        b_reg     <= sub ? ~op_b : op_b;
                        carry_reg <= sub ? 1'b1 : cin_in;
`else
                        b_reg     <= op_b;
                        carry_reg <= cin_in;
`endif
                        acc   <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc       <= acc_nxt;
                    carry_reg <= add_carry;
                    if (last) begin
                        result <= acc_nxt;
                        cout   <= add_carry;
                        done   <= 1'b1;
                        idx    <= '0;
                        state  <= FIN;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl (NIBBLES=4) with a behavioural 4-bit adder on the ADD ports.
// Define SUB_EN for both files to exercise subtract mode.
module tb_nibble_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] op_a, op_b;
    logic        cin_in;
`ifdef SUB_EN
    logic        sub;
`endif
    logic        busy, done, cout;
    logic [15:0] result;
    logic [3:0]  add_a, add_b, add_sum;
    logic        add_cin, add_carry;
    logic [4:0]  add_full;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign add_full  = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
    assign add_sum   = add_full[3:0];
    assign add_carry = add_full[4];

    nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin_in    (cin_in),
`ifdef SUB_EN
        .sub       (sub),
`endif
        .busy      (busy),
        .done      (done),
        .result    (result),
        .cout      (cout),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_carry (add_carry)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction: lat = edges from acceptance to the DONE cycle, aseq = add_a nibbles in RUN order
    task automatic do_add(input logic [15:0] a, input logic [15:0] b, input logic c,
                          output logic [15:0] res, output logic co,
                          output int lat, output int busy_n, output logic [15:0] aseq);
        @(negedge clk);
        op_a = a; op_b = b; cin_in = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; busy_n = 0; aseq = '0; res = '0; co = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            if (busy) busy_n++;
            if (busy && !done) aseq = {aseq[11:0], add_a};
            if (done) begin
                lat = i; res = result; co = cout;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    logic [15:0] res, aseq;
    logic        co;
    int          lat, busy_n, prev, ndone;

    initial begin
        rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cin_in = 1'b0;
`ifdef SUB_EN
        sub = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_cout", cout, 0);
        check("rst_add", {add_a, add_b, add_cin}, 0);
        @(negedge clk) rst_n = 1'b1;

        // 1: full carry ripple through every nibble
        do_add(16'hFFFF, 16'h0001, 1'b0, res, co, lat, busy_n, aseq);
        check("t1_result", res, 16'h0000);
        check("t1_cout", co, 1);
        check("t1_lat", lat, 4);
        check("t1_busy", busy_n, 5);
        check("t1_idle_add", {busy, add_a, add_b, add_cin}, 0);

        // 2: nibble order on the adder port
        do_add(16'h1234, 16'h4321, 1'b0, res, co, lat, busy_n, aseq);
        check("t2_result", res, 16'h5555);
        check("t2_cout", co, 0);
        check("t2_aseq", aseq, 16'h4321);
        check("t2_hold", result, 16'h5555);

        // 3: carry-in honoured, then back-to-back transaction
        do_add(16'h0001, 16'h0000, 1'b1, res, co, lat, busy_n, aseq);
        check("t3a_result", res, 16'h0002);
        check("t3a_cout", co, 0);
        do_add(16'h000D, 16'h0002, 1'b0, res, co, lat, busy_n, aseq);
        check("t3b_result", res, 16'h000F);

        // 4: start held high; operands scrambled during RUN must not matter
        @(negedge clk);
        op_a = 16'h00FF; op_b = 16'h0001; cin_in = 1'b0; start = 1'b1;
        prev = -1; ndone = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                check("t4_result", result, 16'h0100);
                check("t4_cout", cout, 0);
                if (prev >= 0) check("t4_period", i - prev, 6);
                prev = i;
                op_a = 16'h00FF; op_b = 16'h0001;
            end else if (busy) begin
                op_a = 16'hA5A5; op_b = 16'h5A5A;
            end
        end
        start = 1'b0;
        check("t4_count", ndone, 4);
        repeat (8) @(posedge clk);

        // 5: asynchronous reset during the second RUN cycle
        @(negedge clk);
        op_a = 16'h0F0F; op_b = 16'h0101; cin_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_outs", {done, cout, result}, 0);
        check("t5_add", {add_a, add_b, add_cin}, 0);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("t5_nodone", ndone, 0);
        @(negedge clk) rst_n = 1'b1;
        do_add(16'h1111, 16'h2222, 1'b0, res, co, lat, busy_n, aseq);
        check("t5_result", res, 16'h3333);
        check("t5_lat", lat, 4);

`ifdef SUB_EN
        // 6: subtract mode
        sub = 1'b1;
        do_add(16'h000D, 16'h0002, 1'b0, res, co, lat, busy_n, aseq);
        check("t6a_result", res, 16'h000B);
        check("t6a_cout", co, 1);
        do_add(16'h0000, 16'h0001, 1'b0, res, co, lat, busy_n, aseq);
        check("t6b_result", res, 16'hFFFF);
        check("t6b_cout", co, 0);
        sub = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
